// File: rtl/freq_stepper.sv
// Inverter switching-frequency owner: steps the half-period on tracker requests at full-period boundaries
// and drives the complementary gate pair. Define DEADTIME_EN to insert DT dead-time cycles per half.
module freq_stepper #(
    parameter int HALF_DEF = 625,
    parameter int HALF_MIN = 500,
    parameter int HALF_MAX = 833,
    parameter int STEP     = 5,
    parameter int DT       = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        freq_rdy,
    input  logic        freq_set_up_down,
    input  logic        freq_opt,
    output logic        gate_a,
    output logic        gate_b,
    output logic [15:0] half_period,
    output logic        period_strobe,
    output logic        locked,
    output logic        at_limit
);

    localparam logic [1:0] A_DT = 2'd0;
    localparam logic [1:0] A_ON = 2'd1;
    localparam logic [1:0] B_DT = 2'd2;
    localparam logic [1:0] B_ON = 2'd3;

`ifdef DEADTIME_EN
    localparam int         DT_LEN  = DT;
    localparam logic [1:0] HALF_A0 = A_DT;
    localparam logic [1:0] HALF_B0 = B_DT;
`else
    // Without dead time the DT states are unreachable; each half starts directly in x_ON.
    localparam int         DT_LEN  = 0 * DT;
    localparam logic [1:0] HALF_A0 = A_ON;
    localparam logic [1:0] HALF_B0 = B_ON;
`endif

    localparam logic [15:0]        DT_M1  = 16'(DT_LEN - 1);
    localparam logic signed [16:0] STEP_S = 17'(STEP);
    localparam logic signed [16:0] MIN_S  = 17'(HALF_MIN);
    localparam logic signed [16:0] MAX_S  = 17'(HALF_MAX);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] half_q, half_d;
    logic        gate_a_q, gate_a_d, gate_b_q, gate_b_d;
    logic        strobe_q, strobe_d;
    logic        locked_q, locked_d;
    logic        at_limit_q, at_limit_d;
    logic        pend_q, pend_d;
    logic        pend_dir_q, pend_dir_d;
    logic        lock_now, rdy_ok, apply_dir;

    // 17-bit signed step with clamp so the count can never wrap.
    function automatic logic [15:0] sat_step(input logic [15:0] h, input logic dn);
        logic signed [16:0] s;
        s = $signed({1'b0, h});
        s = dn ? (s - STEP_S) : (s + STEP_S);
        if (s < MIN_S) return 16'(HALF_MIN);
        if (s > MAX_S) return 16'(HALF_MAX);
        return s[15:0];
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        if (!en) begin
            state_d = HALF_A0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                A_DT: if (cnt_q == DT_M1) state_d = A_ON;
                B_DT: if (cnt_q == DT_M1) state_d = B_ON;
                A_ON: if (cnt_q == half_q - 16'd1) begin
                    state_d = HALF_B0;
                    cnt_d   = '0;
                end
                default: if (cnt_q == half_q - 16'd1) begin
                    state_d = HALF_A0;
                    cnt_d   = '0;
                end
            endcase
        end
        gate_a_d = en && (state_d == A_ON);
        gate_b_d = en && (state_d == B_ON);
        strobe_d = en && (state_d == B_ON) && (cnt_d == half_q - 16'd1);
    end

    // A freq_opt in the current cycle locks immediately, so a coincident step is dropped.
    always_comb begin
        lock_now   = locked_q | freq_opt;
        rdy_ok     = freq_rdy && !lock_now;
        apply_dir  = rdy_ok ? freq_set_up_down : pend_dir_q;
        pend_d     = pend_q;
        pend_dir_d = pend_dir_q;
        half_d     = half_q;
        if (rdy_ok) begin
            pend_d     = 1'b1;
            pend_dir_d = freq_set_up_down;
        end
        if (strobe_q) begin
            if (!lock_now && (pend_q || rdy_ok)) half_d = sat_step(half_q, apply_dir);
            pend_d = 1'b0;
        end
        if (lock_now) pend_d = 1'b0;
        locked_d   = lock_now;
        at_limit_d = (half_d == 16'(HALF_MIN)) || (half_d == 16'(HALF_MAX));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HALF_A0;
            cnt_q      <= '0;
            half_q     <= 16'(HALF_DEF);
            gate_a_q   <= 1'b0;
            gate_b_q   <= 1'b0;
            strobe_q   <= 1'b0;
            locked_q   <= 1'b0;
            at_limit_q <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            gate_a_q   <= gate_a_d;
            gate_b_q   <= gate_b_d;
            strobe_q   <= strobe_d;
            locked_q   <= locked_d;
            at_limit_q <= at_limit_d;
            pend_q     <= pend_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_dir_q <= pend_dir_d;
    end

    assign gate_a        = gate_a_q;
    assign gate_b        = gate_b_q;
    assign half_period   = half_q;
    assign period_strobe = strobe_q;
    assign locked        = locked_q;
    assign at_limit      = at_limit_q;

endmodule
